// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
package uart_pkg;

   localparam int unsigned BAUD_DIV_DEFAULT = 2604;
   localparam int unsigned FRAME_BITS       = 10;

   typedef enum logic {
      IDLE = 1'b0,
      XMIT = 1'b1
   } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time down-counter: reload on i_load, count while enabled, tick at zero.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned DIV = BAUD_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_tick
);

   localparam int unsigned W = $clog2(DIV);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= W'(DIV - 1);
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, one-byte holding register for back-to-back bytes.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   input  logic       clr_tx_done,
   output logic       TX,
   output logic       tx_rdy,
   output logic       tx_busy,
   output logic       tx_done
);

   uart_state_e           r_state;
   logic [FRAME_BITS-1:0] r_shift;
   logic [7:0]            r_hold;
   logic                  r_hold_vld;
   logic [3:0]            r_bitcnt;
   logic                  r_done;

   logic w_tick;
   logic w_load;
   logic w_last;
   logic w_accept;

   assign w_accept = trmt && !r_hold_vld;
   assign w_last   = w_tick && (r_bitcnt == 4'(FRAME_BITS - 1));
   assign w_load   = ((r_state == IDLE) && trmt) || w_tick;

   uart_baud_tick #(
      .DIV (BAUD_DIV)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_en   (r_state == XMIT),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shift    <= '1;
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
         r_bitcnt   <= '0;
         r_done     <= 1'b0;
      end else begin
         if (clr_tx_done || w_accept) begin
            r_done <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (trmt) begin
                  r_shift  <= {1'b1, tx_data, 1'b0};
                  r_bitcnt <= '0;
                  r_state  <= XMIT;
               end
            end
            XMIT: begin
               // At frame end an accepted byte bypasses the holding register.
               if (w_accept && !w_last) begin
                  r_hold     <= tx_data;
                  r_hold_vld <= 1'b1;
               end
               if (w_last) begin
                  if (r_hold_vld) begin
                     r_shift    <= {1'b1, r_hold, 1'b0};
                     r_hold_vld <= 1'b0;
                     r_bitcnt   <= '0;
                  end else if (trmt) begin
                     r_shift  <= {1'b1, tx_data, 1'b0};
                     r_bitcnt <= '0;
                  end else begin
                     r_shift  <= '1;
                     r_bitcnt <= r_bitcnt + 4'd1;
                     r_state  <= IDLE;
                     r_done   <= 1'b1;
                  end
               end else if (w_tick) begin
                  r_shift  <= {1'b1, r_shift[FRAME_BITS-1:1]};
                  r_bitcnt <= r_bitcnt + 4'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign TX      = r_shift[0];
   assign tx_rdy  = ~r_hold_vld;
   assign tx_busy = (r_state == XMIT);
   assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed bytes into a frame scoreboard, serial-line monitor pops and compares.
module tb_uart_tx;

   localparam int unsigned D    = 4;
   localparam int unsigned SLOW = 2604;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       trmt = 1'b0;
   logic [7:0] tx_data = '0;
   logic       clr = 1'b0;
   logic       TX, tx_rdy, tx_busy, tx_done;

   logic       s_trmt = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_TX, s_rdy, s_busy, s_done;

   uart_tx #(.BAUD_DIV(D)) dut (
      .clk(clk), .rst(rst), .trmt(trmt), .tx_data(tx_data), .clr_tx_done(clr),
      .TX(TX), .tx_rdy(tx_rdy), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   uart_tx #(.BAUD_DIV(SLOW)) dut_slow (
      .clk(clk), .rst(rst), .trmt(s_trmt), .tx_data(s_data), .clr_tx_done(1'b0),
      .TX(s_TX), .tx_rdy(s_rdy), .tx_busy(s_busy), .tx_done(s_done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] data;
      bit         contig;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] d, input bit c);
      exp_t e;
      e.data   = d;
      e.contig = c;
      sb.push_back(e);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic accept(input logic [7:0] d, output int unsigned at);
      trmt    = 1'b1;
      tx_data = d;
      tick(1);
      trmt    = 1'b0;
      at      = cyc;
   endtask

   task automatic wait_until(input int unsigned target);
      while (cyc < target) tick(1);
   endtask

   // Serial-line monitor: every frame is sampled cycle by cycle on the falling edge.
   initial begin : monitor
      logic        prev;
      logic [9:0]  got;
      int unsigned unstable, start, last_start;
      bit          aborted;
      exp_t        e;
      prev       = 1'b1;
      last_start = 0;
      forever begin
         @(negedge clk);
         if (!rst && prev === 1'b1 && TX === 1'b0) begin
            start    = cyc;
            got      = '0;
            unstable = 0;
            aborted  = 1'b0;
            for (int unsigned k = 0; k < 10 * D; k++) begin
               if (k != 0) @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               if (k % D == 0) got[k / D] = TX;
               else if (TX !== got[k / D]) unstable++;
            end
            if (!aborted) begin
               check("frame expected", 32'(sb.size() > 0), 32'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("frame bits", 32'(got), 32'({1'b1, e.data, 1'b0}));
                  check("bit stability", unstable, 0);
                  if (e.contig) check("frame gap", start - last_start, 10 * D);
               end
               last_start = start;
            end
         end
         prev = TX;
      end
   end

   initial begin : stim
      int unsigned a, b, n;

      tick(3);
      check("reset TX", 32'(TX), 1);
      check("reset tx_rdy", 32'(tx_rdy), 1);
      check("reset tx_busy", 32'(tx_busy), 0);
      check("reset tx_done", 32'(tx_done), 0);
      rst = 1'b0;
      tick(2);

      // Single frame from idle
      push(8'hA5, 1'b0);
      accept(8'hA5, a);
      check("TX low after accept", 32'(TX), 0);
      check("busy in frame", 32'(tx_busy), 1);
      wait_until(a + 10 * D - 1);
      check("done before frame end", 32'(tx_done), 0);
      tick(1);
      check("done at frame end", 32'(tx_done), 1);
      check("busy after frame", 32'(tx_busy), 0);
      check("TX idle after frame", 32'(TX), 1);

      // Held byte, ignored third byte while full
      tick(3);
      push(8'h55, 1'b0);
      accept(8'h55, a);
      check("done cleared by trmt", 32'(tx_done), 0);
      tick(2);
      push(8'h0F, 1'b1);
      accept(8'h0F, b);
      check("rdy low with held byte", 32'(tx_rdy), 0);
      tick(2);
      trmt = 1'b1;
      tx_data = 8'hFF;
      tick(3);
      trmt = 1'b0;
      check("rdy low after ignored trmt", 32'(tx_rdy), 0);
      while (!tx_rdy && cyc < a + 100) tick(1);
      check("rdy returns at second load", cyc - a, 10 * D);
      check("no done between frames", 32'(tx_done), 0);
      wait_until(a + 20 * D - 1);
      check("done before second end", 32'(tx_done), 0);
      tick(1);
      check("done after second frame", 32'(tx_done), 1);
      check("idle after second frame", 32'(tx_busy), 0);

      // trmt exactly at frame end with empty holding register
      tick(2);
      push(8'h3C, 1'b0);
      accept(8'h3C, a);
      wait_until(a + 10 * D - 1);
      push(8'hC3, 1'b1);
      trmt = 1'b1;
      tx_data = 8'hC3;
      tick(1);
      trmt = 1'b0;
      check("busy through direct reload", 32'(tx_busy), 1);
      check("no done on direct reload", 32'(tx_done), 0);
      check("rdy on direct reload", 32'(tx_rdy), 1);
      wait_until(a + 20 * D);
      check("done after direct reload frame", 32'(tx_done), 1);

      // Set wins over clr_tx_done, then clear
      tick(2);
      push(8'h81, 1'b0);
      accept(8'h81, a);
      wait_until(a + 10 * D - 1);
      clr = 1'b1;
      tick(1);
      check("set wins over clr", 32'(tx_done), 1);
      tick(1);
      check("clr clears done", 32'(tx_done), 0);
      clr = 1'b0;

      // Reset mid-frame with a held byte
      tick(2);
      accept(8'h96, a);
      tick(1);
      accept(8'h69, b);
      check("rdy low before abort", 32'(tx_rdy), 0);
      wait_until(a + 5 * D + 1);
      rst = 1'b1;
      tick(1);
      check("abort TX", 32'(TX), 1);
      check("abort tx_rdy", 32'(tx_rdy), 1);
      check("abort tx_busy", 32'(tx_busy), 0);
      check("abort tx_done", 32'(tx_done), 0);
      tick(1);
      rst = 1'b0;
      tick(10);
      check("held byte discarded", 32'(TX), 1);
      push(8'h3A, 1'b0);
      accept(8'h3A, a);
      wait_until(a + 10 * D);
      check("done after clean frame", 32'(tx_done), 1);

      // Full-rate divider: 0x00 is 9 low bit times then the stop bit
      tick(2);
      s_trmt = 1'b1;
      s_data = 8'h00;
      tick(1);
      s_trmt = 1'b0;
      n = 0;
      while (s_TX === 1'b0 && n < 30000) begin
         n++;
         tick(1);
      end
      check("slow low cycles", n, 9 * SLOW);
      n = 0;
      while (s_TX === 1'b1 && s_busy === 1'b1 && n < 5000) begin
         n++;
         tick(1);
      end
      check("slow stop cycles", n, SLOW);
      check("slow done", 32'(s_done), 1);

      tick(5);
      check("scoreboard drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: BAUD_DIV, 2604, clocks per bit time (19200 baud at 50 MHz); legal range 2..4095.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: trmt  input  1  request to transmit tx_data; accepted only when tx_rdy=1.
REQ-005 SHALL have port: tx_data  input  8  byte to send; sampled on the edge trmt is accepted.
REQ-006 SHALL have port: clr_tx_done  input  1  clears tx_done.
REQ-007 SHALL have port: TX  output  1  serial line, idle high; driven directly from a flop.
REQ-008 SHALL have port: tx_rdy  output  1  holding register empty; can accept trmt.
REQ-009 SHALL have port: tx_busy  output  1  high while in state XMIT.
REQ-010 SHALL have port: tx_done  output  1  set/reset flag: transmitter went idle after a frame.

Function
REQ-011 SHALL send frames of start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly BAUD_DIV clocks; frame exactly 10*BAUD_DIV clocks.
REQ-012 SHALL use a 10-bit shift register loaded with {1, data, 0}, shifting right with 1 filled in; TX = shift_reg[0].
REQ-013 SHALL use a baud down-counter loaded with BAUD_DIV-1 at frame load and at each shift; shift when it reaches 0 in XMIT.
REQ-014 SHALL use a 4-bit bit counter, cleared at frame load, incremented on each shift; frame ends on the shift that makes it 10.
REQ-015 SHALL implement states IDLE and XMIT only; the counters hold and do not toggle in IDLE.
REQ-016 IDLE: accepted trmt loads the shifter directly (holding register bypassed) and goes to XMIT; TX goes low one clock after the accepting edge.
REQ-017 XMIT: accepted trmt writes the 8-bit holding register; tx_rdy goes 0 the following cycle.
REQ-018 At frame end with holding register full: load the shifter from the holding register, stay in XMIT, set tx_rdy=1; no idle gap on TX.
REQ-019 At frame end with holding register empty and trmt=1 that cycle: load the shifter from tx_data, stay in XMIT.
REQ-020 At frame end with holding register empty and trmt=0: go to IDLE, TX=1, set tx_done.
REQ-021 trmt while tx_rdy=0 SHALL be ignored; data is neither dropped from the holding register nor overwritten.
REQ-022 tx_done SHALL clear on an accepted trmt or on clr_tx_done; a set in the same cycle wins over clr_tx_done.
REQ-023 tx_rdy SHALL equal NOT holding-valid; tx_busy SHALL equal (state==XMIT); neither depends combinationally on inputs.

Reset
REQ-024 On rst: state=IDLE, TX=1, shift_reg=all ones, holding register invalid, tx_rdy=1, tx_busy=0, tx_done=0, counters=0.
REQ-025 rst during a frame SHALL abort it: TX=1 after the reset edge, pending held byte discarded, no tx_done.

Structure
REQ-026 Shared package uart_pkg SHALL hold the BAUD_DIV default, FRAME_BITS=10, and the IDLE/XMIT state encoding; the receiver uses the same package.
REQ-027 Baud counter SHALL be a sub-module uart_baud_tick (load, enable, tick out), sized ceil(log2(BAUD_DIV)) bits.

Verification
REQ-028 BAUD_DIV=4; trmt with 0xA5 in IDLE -> TX low from the next cycle; bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks; tx_done=1 at clock 41; tx_busy=0.
REQ-029 BAUD_DIV=4; 0x55, then 0x0F while busy -> tx_rdy=0; second frame starts right after the first stop bit; 80 contiguous clocks; one tx_done.
REQ-030 Holding register full, third trmt with 0xFF -> ignored; TX carries the first two bytes only; tx_rdy returns 1 at the second frame load.
REQ-031 clr_tx_done asserted in the same cycle as the frame-end set -> tx_done=1; clr_tx_done later -> tx_done=0 next cycle.
REQ-032 rst asserted at bit 5 of the frame with a held byte -> TX=1, tx_rdy=1, tx_busy=0, tx_done=0; next trmt sends a clean frame.
REQ-033 BAUD_DIV=2604; send 0x00 -> TX low for exactly 9*2604 clocks, then high for 2604.
